// File: rtl/alu_rr_sched.sv
// Round-robin scheduler sharing one registered 4-bit ALU between NREQ requesters.
// Opcodes: 0000 and, 0001 or, 0010 xor, 0011 nand, 0100 not a, 1000 add, 1001 sub, 1010 mul, 1011 div, 1100 mod.
module alu_rr_alu (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic [3:0] op,
   output logic [7:0] y
);
   logic [7:0] y_q, y_d, ax, bx;

   always_comb begin
      ax  = {4'd0, a};
      bx  = {4'd0, b};
      y_d = y_q;
      if (en) begin
         case (op)
            4'b0000: y_d = ax & bx;
            4'b0001: y_d = ax | bx;
            4'b0010: y_d = ax ^ bx;
            4'b0011: y_d = {4'd0, ~(a & b)};
            4'b0100: y_d = {4'd0, ~a};
            4'b1000: y_d = ax + bx;
            4'b1001: y_d = ax - bx;
            4'b1010: y_d = ax * bx;
            4'b1011: y_d = (b != 4'd0) ? ax / bx : 8'd0;
            4'b1100: y_d = (b != 4'd0) ? ax % bx : 8'd0;
            default: y_d = 8'd0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) y_q <= 8'd0;
      else     y_q <= y_d;
   end

   assign y = y_q;
endmodule

module alu_rr_sched #(
   parameter int NREQ = 4,
   parameter int IDW  = 3,
   parameter int CNTW = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [4*NREQ-1:0] req_a,
   input  logic [4*NREQ-1:0] req_b,
   input  logic [4*NREQ-1:0] req_op,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [IDW-1:0]    rsp_id,
   output logic [7:0]        rsp_data,
   output logic              rsp_err,
   output logic [CNTW-1:0]   done_cnt,
   output logic              busy
);
   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_CAPT, S_RESP} state_t;

   state_t          state_q, state_d;
   logic [IDW-1:0]  rr_ptr_q, rr_ptr_d, id_q, id_d, win_id, rsp_id_q, rsp_id_d;
   logic [3:0]      a_q, a_d, b_q, b_d, op_q, op_d, a_sel, b_sel, op_sel;
   logic [7:0]      rsp_data_q, rsp_data_d, alu_y;
   logic            rsp_err_q, rsp_err_d, rsp_valid_q, rsp_valid_d;
   logic [CNTW-1:0] done_cnt_q, done_cnt_d;
   logic            grant_vld, accept, div_zero;
   int              idx;

   // Scan from rr_ptr upward, wrapping at NREQ; first valid requester wins.
   always_comb begin
      grant_vld = 1'b0;
      win_id    = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = int'(rr_ptr_q) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!grant_vld && req_valid[idx]) begin
            grant_vld = 1'b1;
            win_id    = IDW'(idx);
         end
      end
   end

   always_comb begin
      a_sel    = req_a[4*int'(win_id) +: 4];
      b_sel    = req_b[4*int'(win_id) +: 4];
      op_sel   = req_op[4*int'(win_id) +: 4];
      div_zero = ((op_sel == 4'b1011) || (op_sel == 4'b1100)) && (b_sel == 4'd0);
      accept   = (state_q == S_IDLE) && grant_vld && !rst;
      req_ready = accept ? ({{(NREQ-1){1'b0}}, 1'b1} << win_id) : '0;
   end

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      id_d        = id_q;
      a_d         = a_q;
      b_d         = b_q;
      op_d        = op_q;
      rsp_id_d    = rsp_id_q;
      rsp_data_d  = rsp_data_q;
      rsp_err_d   = rsp_err_q;
      done_cnt_d  = done_cnt_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               id_d     = win_id;
               a_d      = a_sel;
               b_d      = b_sel;
               op_d     = op_sel;
               rr_ptr_d = (win_id == IDW'(NREQ-1)) ? '0 : win_id + 1'b1;
               if (div_zero) begin
                  rsp_id_d   = win_id;
                  rsp_data_d = 8'd0;
                  rsp_err_d  = 1'b1;
                  state_d    = S_RESP;
               end else begin
                  state_d    = S_EXEC;
               end
            end
         end
         S_EXEC: state_d = S_CAPT;
         S_CAPT: begin
            rsp_id_d   = id_q;
            rsp_data_d = alu_y;
            rsp_err_d  = 1'b0;
            state_d    = S_RESP;
         end
         S_RESP: begin
            if (rsp_ready) begin
               if (done_cnt_q != {CNTW{1'b1}}) done_cnt_d = done_cnt_q + 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      rsp_valid_d = (state_d == S_RESP);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         rr_ptr_q    <= '0;
         id_q        <= '0;
         a_q         <= 4'd0;
         b_q         <= 4'd0;
         op_q        <= 4'd0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_data_q  <= 8'd0;
         rsp_err_q   <= 1'b0;
         done_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         id_q        <= id_d;
         a_q         <= a_d;
         b_q         <= b_d;
         op_q        <= op_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_data_q  <= rsp_data_d;
         rsp_err_q   <= rsp_err_d;
         done_cnt_q  <= done_cnt_d;
      end
   end

   // The ALU only samples in EXEC, so the error path never disturbs it.
   alu_rr_alu u_alu (
      .clk (clk),
      .rst (rst),
      .en  (state_q == S_EXEC),
      .a   (a_q),
      .b   (b_q),
      .op  (op_q),
      .y   (alu_y)
   );

   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_err   = rsp_err_q;
   assign done_cnt  = done_cnt_q;
   assign busy      = (state_q != S_IDLE);
endmodule

// File: tb/tb_alu_rr_sched.sv
// Scoreboard bench for alu_rr_sched; a second CNTW=4 instance shares stimulus for counter saturation.
module tb_alu_rr_sched;
   localparam int NREQ = 4;
   localparam int IDW  = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [NREQ-1:0]   req_valid, req_ready, d4_req_ready;
   logic [4*NREQ-1:0] req_a, req_b, req_op;
   logic              rsp_ready, rsp_valid, rsp_err, busy;
   logic [IDW-1:0]    rsp_id;
   logic [7:0]        rsp_data;
   logic [15:0]       done_cnt;
   logic              d4_rsp_valid, d4_rsp_err, d4_busy;
   logic [IDW-1:0]    d4_rsp_id;
   logic [7:0]        d4_rsp_data;
   logic [3:0]        d4_done_cnt;

   alu_rr_sched #(.NREQ(NREQ), .IDW(IDW), .CNTW(16)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_op(req_op),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_data(rsp_data), .rsp_err(rsp_err), .done_cnt(done_cnt), .busy(busy)
   );

   alu_rr_sched #(.NREQ(NREQ), .IDW(IDW), .CNTW(4)) dut4 (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(d4_req_ready),
      .req_a(req_a), .req_b(req_b), .req_op(req_op),
      .rsp_valid(d4_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(d4_rsp_id),
      .rsp_data(d4_rsp_data), .rsp_err(d4_rsp_err), .done_cnt(d4_done_cnt), .busy(d4_busy)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [8:0] alu_ref(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
      logic [7:0] r;
      logic       e;
      e = 1'b0;
      case (op)
         4'b0000: r = {4'd0, a & b};
         4'b0001: r = {4'd0, a | b};
         4'b0010: r = {4'd0, a ^ b};
         4'b0011: r = {4'd0, ~(a & b)};
         4'b0100: r = {4'd0, ~a};
         4'b1000: r = 8'(a) + 8'(b);
         4'b1001: r = 8'(a) - 8'(b);
         4'b1010: r = 8'(a) * 8'(b);
         4'b1011: begin if (b == 0) begin r = 0; e = 1; end else r = 8'(a / b); end
         4'b1100: begin if (b == 0) begin r = 0; e = 1; end else r = 8'(a % b); end
         default: r = 8'd0;
      endcase
      return {e, r};
   endfunction

   typedef struct packed { logic [2:0] id; logic [7:0] data; logic err; } rsp_t;
   typedef enum { M_IDLE, M_EXEC, M_CAPT, M_RESP } mst_t;

   rsp_t       exp_q[$];
   int         grant_id_q[$];
   int         grant_cyc_q[$];
   mst_t       m_st = M_IDLE;
   int         m_ptr = 0;
   int         m_done = 0;
   int         cyc = 0;
   logic       armed = 1'b0;
   int         win, sidx;
   logic [3:0] exp_rdy;
   logic [8:0] ref_r;
   rsp_t       ent;

   // Reference model of the scheduler, stepped once per cycle on the falling edge.
   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         armed  = 1'b1;
         m_st   = M_IDLE;
         m_ptr  = 0;
         m_done = 0;
         exp_q.delete();
      end else if (armed) begin
         win     = -1;
         exp_rdy = '0;
         if (m_st == M_IDLE)
            for (int k = 0; k < NREQ; k++) begin
               sidx = (m_ptr + k) % NREQ;
               if (win < 0 && req_valid[sidx]) win = sidx;
            end
         if (win >= 0) exp_rdy[win] = 1'b1;
         chk("req_ready", 32'(req_ready), 32'(exp_rdy));
         chk("busy", 32'(busy), 32'(m_st != M_IDLE));
         chk("rsp_valid", 32'(rsp_valid), 32'(m_st == M_RESP));
         chk("done_cnt", 32'(done_cnt), 32'(m_done));
         chk("done_cnt_sat4", 32'(d4_done_cnt), 32'((m_done > 15) ? 15 : m_done));
         if (m_st == M_RESP) begin
            if (exp_q.size() != 1) chk("rsp_queue_depth", 32'(exp_q.size()), 32'd1);
            else begin
               chk("rsp_id", 32'(rsp_id), 32'(exp_q[0].id));
               chk("rsp_data", 32'(rsp_data), 32'(exp_q[0].data));
               chk("rsp_err", 32'(rsp_err), 32'(exp_q[0].err));
            end
         end
         case (m_st)
            M_IDLE: if (win >= 0) begin
               ref_r    = alu_ref(req_op[4*win +: 4], req_a[4*win +: 4], req_b[4*win +: 4]);
               ent.id   = 3'(win);
               ent.data = ref_r[7:0];
               ent.err  = ref_r[8];
               exp_q.push_back(ent);
               grant_id_q.push_back(win);
               grant_cyc_q.push_back(cyc);
               m_ptr = (win + 1) % NREQ;
               m_st  = ref_r[8] ? M_RESP : M_EXEC;
            end
            M_EXEC: m_st = M_CAPT;
            M_CAPT: m_st = M_RESP;
            M_RESP: if (rsp_ready) begin
               void'(exp_q.pop_front());
               m_done++;
               m_st = M_IDLE;
            end
            default: m_st = M_IDLE;
         endcase
      end
   end

   task automatic set_req(input int id, input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
      req_a[4*id +: 4]  = a;
      req_b[4*id +: 4]  = b;
      req_op[4*id +: 4] = op;
   endtask

   task automatic issue(input int id, input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
      logic seen;
      seen = 1'b0;
      set_req(id, a, b, op);
      req_valid[id] = 1'b1;
      for (int t = 0; t < 60 && !seen; t++) begin
         @(negedge clk);
         seen = req_ready[id];
      end
      chk("grant_seen", 32'(seen), 32'd1);
      @(posedge clk); #1;
      req_valid[id] = 1'b0;
   endtask

   task automatic wait_idle();
      logic done;
      done = 1'b0;
      for (int t = 0; t < 100 && !done; t++) begin
         @(posedge clk); #1;
         done = (m_st == M_IDLE) && (exp_q.size() == 0);
      end
      chk("idle_reached", 32'(done), 32'd1);
   endtask

   task automatic wait_grants(input int n);
      for (int t = 0; t < 200 && grant_id_q.size() < n; t++) begin
         @(posedge clk); #1;
      end
      chk("grant_count", 32'(grant_id_q.size() >= n), 32'd1);
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   int exp_order[5] = '{0, 1, 2, 3, 0};

   initial begin
      req_valid = '0; req_a = '0; req_b = '0; req_op = '0; rsp_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_id", 32'(rsp_id), 32'd0);
      chk("rst_rsp_data", 32'(rsp_data), 32'd0);
      chk("rst_rsp_err", 32'(rsp_err), 32'd0);
      chk("rst_done_cnt", 32'(done_cnt), 32'd0);
      @(posedge clk); #1;

      // Single add from requester 2.
      issue(2, 4'd9, 4'd3, 4'b1000);
      wait_idle();
      chk("add_done_cnt", 32'(done_cnt), 32'd1);

      // All requesters continuously valid: rotation and 4-cycle spacing.
      pulse_reset();
      grant_id_q.delete(); grant_cyc_q.delete();
      for (int i = 0; i < NREQ; i++) set_req(i, 4'hA, 4'h5, 4'b0010);
      req_valid = '1;
      wait_grants(5);
      req_valid = '0;
      if (grant_id_q.size() >= 5)
         for (int i = 0; i < 5; i++) begin
            chk("rr_order", 32'(grant_id_q[i]), 32'(exp_order[i]));
            if (i > 0) chk("rr_interval", 32'(grant_cyc_q[i] - grant_cyc_q[i-1]), 32'd4);
         end
      wait_idle();

      // Divide by zero, then a legal divide.
      grant_cyc_q.delete();
      issue(1, 4'd5, 4'd0, 4'b1011);
      wait_idle();
      issue(1, 4'd8, 4'd2, 4'b1011);
      wait_idle();

      // Backpressure on a multiply.
      rsp_ready = 1'b0;
      issue(0, 4'd15, 4'd15, 4'b1010);
      for (int t = 0; t < 20 && !rsp_valid; t++) @(negedge clk);
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      repeat (5) @(negedge clk);
      chk("bp_rsp_data", 32'(rsp_data), 32'd225);
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      wait_idle();

      // Reset while an op is in EXEC; round-robin pointer must restart at 0.
      issue(1, 4'd3, 4'd4, 4'b1000);
      set_req(1, 4'd0, 4'd0, 4'b0000);
      pulse_reset();
      @(negedge clk);
      chk("exec_rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("exec_rst_busy", 32'(busy), 32'd0);
      chk("exec_rst_done_cnt", 32'(done_cnt), 32'd0);
      repeat (6) @(negedge clk);
      @(posedge clk); #1;
      grant_id_q.delete();
      set_req(1, 4'd1, 4'd1, 4'b1000);
      set_req(3, 4'd1, 4'd1, 4'b1000);
      req_valid = 4'b1010;
      wait_grants(1);
      req_valid = '0;
      if (grant_id_q.size() >= 1) chk("ptr_after_rst", 32'(grant_id_q[0]), 32'd1);
      wait_idle();

      // Saturation of the CNTW=4 counter via fast error-path completions.
      for (int i = 0; i < 16; i++) begin
         issue(0, 4'd1, 4'd0, 4'b1100);
         wait_idle();
      end
      chk("sat4_done_cnt", 32'(d4_done_cnt), 32'hF);
      chk("main_done_cnt", 32'(done_cnt), 32'd17);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
